mem_ctrl: RTL and testbench

Byte-serial memory controller that shares the SoC's single 8-bit RAM port between the CPU's instruction-fetch (IF) stage and its load/store (MEM) stage. It sits between the core's pipeline stages and the RAM inside the minimal SoC. It serializes 8/16/32-bit accesses into little-endian byte transfers and reassembles read data into 32-bit words. Data accesses take priority over fetches, and an in-flight fetch can be squashed on a pipeline flush.

---
 rtl/mem_ctrl_if.sv | 35 +++
 rtl/mem_ctrl.sv | 102 ++++++++++
 tb/tb_mem_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundle of the fetch, load/store and byte-wide RAM signals around mem_ctrl.
//   fetch : if_req, if_addr, if_flush -> if_data, if_done
//   data  : mem_req, mem_we, mem_len, mem_addr, mem_wdata -> mem_rdata, mem_done
//   ram   : ram_din -> ram_dout, ram_a, ram_wr
//   slave modport is the controller; master modport is the core plus RAM around it.
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_flush;
   logic [31:0]           if_data;
   logic                  if_done;
   logic                  mem_req;
   logic                  mem_we;
   logic [1:0]            mem_len;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;
   logic                  mem_done;
   logic [7:0]            ram_din;
   logic [7:0]            ram_dout;
   logic [ADDR_WIDTH-1:0] ram_a;
   logic                  ram_wr;

   modport slave (
      input  if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
      output if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
   );

   modport master (
      output if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
      input  if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and load/store, serialising
// 8/16/32-bit little-endian accesses and reassembling read bytes into a zero-extended word.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : mem_ctrl_if.slave carrying the fetch, data and RAM signals
module mem_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state, state_n;
   logic                  owner_mem;
   logic                  we;
   logic [ADDR_WIDTH-1:0] base;
   logic [2:0]            n;
   logic [2:0]            cnt;
   logic [31:0]           wdata;
   logic [31:0]           acc;
   logic                  grant_mem, grant_if, grant, flush, fin, issue, wr_n, cap_en;
   logic [ADDR_WIDTH-1:0] a_n;
   logic [7:0]            dout_n;
   logic [31:0]           wd_sh, cap;
   logic [2:0]            n_in;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;

   // cnt is the index of the edge about to occur, counted from the grant edge (E0).
   // Writes finish at E_n, reads at E_(n+1) when the last byte is on ram_din.
   always_comb begin
      state_n = state;
      grant_mem = 1'b0;
      grant_if = 1'b0;
      flush = 1'b0;
      fin = 1'b0;
      if (state == IDLE) begin
         grant_mem = bus.mem_req;
         grant_if = !bus.mem_req && bus.if_req && !bus.if_flush;
         if (grant_mem || grant_if) state_n = BUSY;
      end else begin
         flush = !owner_mem && bus.if_flush;
         fin = !flush && (cnt == (we ? n : n + 3'd1));
         if (flush || fin) state_n = IDLE;
      end
   end

   assign grant = grant_mem || grant_if;
   assign n_in = grant_if ? 3'd4 : bus.mem_len == 2'd0 ? 3'd1 : bus.mem_len == 2'd1 ? 3'd2 : 3'd4;
   // The grant edge issues byte 0 straight from the request inputs; later bytes use latched fields.
   assign issue = grant || (state == BUSY && !flush && !fin && cnt < n);
   assign wd_sh = wdata >> {cnt[1:0], 3'b000};
   assign wr_n = issue && (grant ? grant_mem && bus.mem_we : we);
   assign a_n = !issue ? '0 : grant ? (grant_mem ? bus.mem_addr : bus.if_addr) : base + ADDR_WIDTH'(cnt);
   assign dout_n = !wr_n ? 8'd0 : grant ? bus.mem_wdata[7:0] : wd_sh[7:0];
   // Byte i arrives one cycle after its issue, so it is captured at edge i+2.
   assign cap_en = state == BUSY && !we && !flush && cnt >= 3'd2;
   assign cap = acc | ({24'd0, bus.ram_din} << {cnt[1:0] - 2'd2, 3'b000});

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         owner_mem <= 1'b0;
         we <= 1'b0;
         base <= '0;
         n <= 3'd0;
         cnt <= 3'd0;
         wdata <= 32'd0;
         acc <= 32'd0;
         bus.ram_a <= '0;
         bus.ram_wr <= 1'b0;
         bus.ram_dout <= 8'd0;
         bus.if_data <= 32'd0;
         bus.if_done <= 1'b0;
         bus.mem_rdata <= 32'd0;
         bus.mem_done <= 1'b0;
      end else begin
         bus.ram_a <= a_n;
         bus.ram_wr <= wr_n;
         bus.ram_dout <= dout_n;
         bus.if_done <= fin && !owner_mem;
         bus.mem_done <= fin && owner_mem;
         if (fin && !we) begin
            if (owner_mem) bus.mem_rdata <= cap;
            else bus.if_data <= cap;
         end
         if (grant) begin
            owner_mem <= grant_mem;
            we <= grant_mem && bus.mem_we;
            base <= grant_mem ? bus.mem_addr : bus.if_addr;
            n <= n_in;
            wdata <= bus.mem_wdata;
            acc <= 32'd0;
            cnt <= 3'd1;
         end else if (state == BUSY) begin
            cnt <= cnt + 3'd1;
            if (cap_en) acc <= cap;
         end
      end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed scoreboard bench for mem_ctrl against a byte-array reference.
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int n_if_done = 0;

   mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();
   mem_ctrl #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [7:0] ram [logic [31:0]];
   logic [7:0] ref_m [logic [31:0]];
   logic [31:0] exp_if [$];
   logic [32:0] exp_mem [$];
   logic [31:0] tr_a [0:19];
   logic tr_w [0:19];

   function automatic logic [7:0] init_byte(logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] rd_ram(logic [31:0] a);
      return ram.exists(a) ? ram[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] rref(logic [31:0] a);
      return ref_m.exists(a) ? ref_m[a] : init_byte(a);
   endfunction

   // RAM with one-cycle read latency
   always @(posedge clk) begin
      if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
      bus.ram_din <= rd_ram(bus.ram_a);
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a done pulse is presented
   always @(negedge clk) begin
      if (bus.if_done) begin
         n_if_done++;
         checks++;
         if (exp_if.size() == 0) begin
            errors++;
            $display("FAIL if_done_unexpected: got data %0h expected no done", bus.if_data);
         end else begin
            logic [31:0] e;
            e = exp_if.pop_front();
            checks++;
            if (bus.if_data !== e) begin
               errors++;
               $display("FAIL if_data: got %0h expected %0h", bus.if_data, e);
            end
         end
      end
      if (bus.mem_done) begin
         checks++;
         if (exp_mem.size() == 0) begin
            errors++;
            $display("FAIL mem_done_unexpected: got data %0h expected no done", bus.mem_rdata);
         end else begin
            logic [32:0] e;
            e = exp_mem.pop_front();
            if (!e[32]) begin
               checks++;
               if (bus.mem_rdata !== e[31:0]) begin
                  errors++;
                  $display("FAIL mem_rdata: got %0h expected %0h", bus.mem_rdata, e[31:0]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pre(input logic [31:0] a, input logic [7:0] b);
      ram[a] = b;
      ref_m[a] = b;
   endtask

   // Waits for the done pulse of one requester; lat = number of edges after the grant edge.
   // Request fields are scrambled after the grant edge to prove they were latched.
   task automatic wait_done(input bit on_if, output int lat);
      lat = -1;
      for (int c = 0; c < 20; c++) begin
         tick();
         tr_a[c] = bus.ram_a;
         tr_w[c] = bus.ram_wr;
         if (c == 0) begin
            if (on_if) bus.if_addr = $urandom;
            else begin
               bus.mem_addr = $urandom;
               bus.mem_wdata = $urandom;
               bus.mem_len = 2'($urandom);
               bus.mem_we = 1'($urandom);
            end
         end
         if (on_if ? bus.if_done : bus.mem_done) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within 20 cycles");
      end
   endtask

   // Computes the expected result from the reference byte array, then runs one transaction.
   task automatic xfer(input bit is_if, input bit w, input logic [1:0] len, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat);
      int n;
      logic [31:0] e;
      n = is_if ? 4 : len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4;
      e = 32'd0;
      for (int i = 0; i < n; i++) begin
         if (w && !is_if) ref_m[addr + 32'(i)] = wd[8*i +: 8];
         else e = e | (32'(rref(addr + 32'(i))) << (8 * i));
      end
      if (is_if) begin
         exp_if.push_back(e);
         bus.if_addr = addr;
         bus.if_req = 1'b1;
      end else begin
         exp_mem.push_back({w, e});
         bus.mem_we = w;
         bus.mem_len = len;
         bus.mem_addr = addr;
         bus.mem_wdata = wd;
         bus.mem_req = 1'b1;
      end
      wait_done(is_if, lat);
      if (lat >= 0) chk(is_if ? "if_latency" : "mem_latency", 128'(lat), 128'((w && !is_if) ? n : n + 1));
      if (is_if) bus.if_req = 1'b0;
      else bus.mem_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat, c0;
      bus.if_req = 1'b0;
      bus.if_addr = 32'd0;
      bus.if_flush = 1'b0;
      bus.mem_req = 1'b0;
      bus.mem_we = 1'b0;
      bus.mem_len = 2'd0;
      bus.mem_addr = 32'd0;
      bus.mem_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {bus.if_data, bus.if_done, bus.mem_rdata, bus.mem_done, bus.ram_dout, bus.ram_a, bus.ram_wr}, 128'd0);
      rst = 1'b0;
      tick();

      // word fetch
      pre(32'h100, 8'h13); pre(32'h101, 8'h05); pre(32'h102, 8'h00); pre(32'h103, 8'h00);
      xfer(1'b1, 1'b0, 2'd2, 32'h100, 32'd0, lat);
      for (int i = 0; i < 4; i++) chk("fetch_addr", tr_a[i], 128'(32'h100 + 32'(i)));
      tick();

      // simultaneous requests: MEM first, IF after the turnaround cycle
      pre(32'h20, 8'hAB);
      exp_mem.push_back({1'b0, 32'h000000AB});
      exp_if.push_back(32'h00000513);
      bus.mem_we = 1'b0; bus.mem_len = 2'd0; bus.mem_addr = 32'h20; bus.mem_req = 1'b1;
      bus.if_addr = 32'h100; bus.if_req = 1'b1;
      wait_done(1'b0, lat);
      chk("simul_mem_latency", 128'(lat), 128'd2);
      bus.mem_req = 1'b0;
      wait_done(1'b1, lat);
      chk("simul_if_latency", 128'(lat), 128'd5);
      bus.if_req = 1'b0;
      tick();

      // word store across a 0x2000 boundary
      xfer(1'b0, 1'b1, 2'd2, 32'h1FFE, 32'hDEADBEEF, lat);
      for (int i = 0; i < 4; i++) begin
         chk("store_addr", tr_a[i], 128'(32'h1FFE + 32'(i)));
         chk("store_wr", 128'(tr_w[i]), 128'd1);
      end
      chk("store_wr_end", 128'(tr_w[4]), 128'd0);
      tick();
      chk("store_bytes", {rd_ram(32'h1FFE), rd_ram(32'h1FFF), rd_ram(32'h2000), rd_ram(32'h2001)}, 128'hEFBEADDE);

      // halfword load wrapping the address space
      pre(32'hFFFFFFFF, 8'h34); pre(32'h0, 8'h12);
      xfer(1'b0, 1'b0, 2'd1, 32'hFFFFFFFF, 32'd0, lat);
      chk("wrap_addr0", tr_a[0], 128'hFFFFFFFF);
      chk("wrap_addr1", tr_a[1], 128'h0);
      tick();

      // flush two cycles into a fetch
      pre(32'h200, 8'h11); pre(32'h201, 8'h22); pre(32'h202, 8'h33); pre(32'h203, 8'h44);
      c0 = n_if_done;
      bus.if_addr = 32'h300; bus.if_req = 1'b1;
      repeat (3) tick();
      bus.if_flush = 1'b1;
      tick();
      chk("flush_idle", {bus.ram_wr, bus.ram_a}, 128'd0);
      bus.if_req = 1'b0; bus.if_flush = 1'b0;
      repeat (7) tick();
      chk("flush_no_done", 128'(n_if_done), 128'(c0));
      xfer(1'b1, 1'b0, 2'd2, 32'h200, 32'd0, lat);
      tick();

      // flush held in idle blocks the fetch grant
      bus.if_addr = 32'h400; bus.if_req = 1'b1; bus.if_flush = 1'b1;
      repeat (3) tick();
      chk("flush_blocks_grant", {bus.ram_wr, bus.ram_a}, 128'd0);
      bus.if_req = 1'b0; bus.if_flush = 1'b0;
      tick();

      // asynchronous reset in the middle of a word store
      bus.mem_we = 1'b1; bus.mem_len = 2'd2; bus.mem_addr = 32'h7000; bus.mem_wdata = 32'hCAFEF00D;
      bus.mem_req = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("reset_abort", {bus.if_data, bus.if_done, bus.mem_rdata, bus.mem_done, bus.ram_dout, bus.ram_a, bus.ram_wr}, 128'd0);
      bus.mem_req = 1'b0;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      chk("reset_quiet", 128'(bus.ram_wr), 128'd0);
      xfer(1'b1, 1'b0, 2'd2, 32'h100, 32'd0, lat);

      // randomized mix on a small window so loads see earlier stores
      for (int k = 0; k < 60; k++) begin
         bit is_if;
         is_if = ($urandom % 3) == 0;
         xfer(is_if, 1'($urandom), 2'($urandom), 32'h1000 + ($urandom % 64), $urandom, lat);
         if ($urandom % 2) tick();
      end
      repeat (3) tick();
      chk("queues_empty", 128'(exp_if.size() + exp_mem.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
